// File: rtl/sysid_check_ctrl.sv
// Avalon-MM master that reads the system-ID slave (ID word, then build timestamp),
// compares both words against build-time constants and reports match/timeout status.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1490652961,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout_err
);

  localparam int unsigned STALL_W = 16;
  localparam int unsigned LAT_W   = 2;
  localparam int unsigned DATA_W  = 32;

  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(READ_LATENCY);
  localparam bit                 HAS_LAT    = (READ_LATENCY != 0);

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_TS,
    WAIT_TS,
    FINISH,
    ABORT
  } state_t;

  state_t             state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [LAT_W-1:0]   lat_q, lat_d;

  logic               read_d;
  logic               addr_d;
  logic [DATA_W-1:0]  id_d, ts_d;
  logic               busy_d, done_d, id_match_d, ts_match_d, timeout_err_d;
  logic               capture;
  logic               phase_ts;

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    stall_d       = stall_q;
    lat_d         = lat_q;
    read_d        = avm_read;
    addr_d        = avm_address;
    id_d          = id_value;
    ts_d          = ts_value;
    done_d        = 1'b0;
    id_match_d    = id_match;
    ts_match_d    = ts_match;
    timeout_err_d = timeout_err;
    capture       = 1'b0;
    phase_ts      = (state_q == RD_TS) || (state_q == WAIT_TS);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_ID;
          addr_d  = 1'b0;
          stall_d = '0;
        end
      end

      // Read strobe is raised one cycle after entering a read state
      RD_ID, RD_TS: begin
        if (!avm_read) begin
          read_d = 1'b1;
        end else if (!avm_waitrequest) begin
          read_d = 1'b0;
          if (HAS_LAT) begin
            lat_d   = LAT_W'(1);
            state_d = phase_ts ? WAIT_TS : WAIT_ID;
          end else begin
            capture = 1'b1;
          end
        end else begin
          stall_d = stall_q + STALL_W'(1);
          if (stall_q == STALL_LAST) begin
            read_d  = 1'b0;
            state_d = ABORT;
          end
        end
      end

      WAIT_ID, WAIT_TS: begin
        if (lat_q == LAT_LAST) begin
          capture = 1'b1;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      FINISH, ABORT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (capture) begin
      if (phase_ts) begin
        ts_d    = avm_readdata;
        state_d = FINISH;
      end else begin
        id_d    = avm_readdata;
        state_d = RD_TS;
        addr_d  = 1'b1;
        stall_d = '0;
      end
    end

    // Status only changes on the way into FINISH or ABORT
    if (state_d == FINISH) begin
      done_d        = 1'b1;
      id_match_d    = (id_d == EXPECTED_ID);
      ts_match_d    = (ts_d == EXPECTED_TS);
      timeout_err_d = 1'b0;
    end else if (state_d == ABORT) begin
      done_d        = 1'b1;
      id_match_d    = 1'b0;
      ts_match_d    = 1'b0;
      timeout_err_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset lands in RD_ID so a check starts automatically
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= RD_ID;
      stall_q     <= '0;
      lat_q       <= '0;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      id_match    <= 1'b0;
      ts_match    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_q     <= stall_d;
      lat_q       <= lat_d;
      avm_read    <= read_d;
      avm_address <= addr_d;
      id_value    <= id_d;
      ts_value    <= ts_d;
      busy        <= busy_d;
      done        <= done_d;
      id_match    <= id_match_d;
      ts_match    <= ts_match_d;
      timeout_err <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: one instance at zero read latency, one at latency 2,
// both driven by the same start/reset and by per-instance system-ID slave stubs.
module tb_sysid_check_ctrl;

  localparam logic [31:0] EXP_TS = 32'd1490652961;
  localparam logic [31:0] BAD_TS = 32'h5AD9_6E22;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] ts;
    logic        idm;
    logic        tsm;
    logic        to;
  } res_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic start   = 1'b0;

  logic        avm_address     [2];
  logic        avm_read        [2];
  logic        avm_waitrequest [2];
  logic [31:0] avm_readdata    [2];
  logic [31:0] id_value        [2];
  logic [31:0] ts_value        [2];
  logic        busy            [2];
  logic        done            [2];
  logic        id_match        [2];
  logic        ts_match        [2];
  logic        timeout_err     [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sysid_check_ctrl #(
      .EXPECTED_ID   (32'd0),
      .EXPECTED_TS   (EXP_TS),
      .READ_LATENCY  ((g == 0) ? 0 : 2),
      .TIMEOUT_CYCLES(8)
    ) dut (
      .clock          (clk),
      .reset_n        (reset_n),
      .start          (start),
      .avm_address    (avm_address[g]),
      .avm_read       (avm_read[g]),
      .avm_waitrequest(avm_waitrequest[g]),
      .avm_readdata   (avm_readdata[g]),
      .id_value       (id_value[g]),
      .ts_value       (ts_value[g]),
      .busy           (busy[g]),
      .done           (done[g]),
      .id_match       (id_match[g]),
      .ts_match       (ts_match[g]),
      .timeout_err    (timeout_err[g])
    );
  end

  // Slave stubs: stall_n waitrequest cycles per read, or stuck forever
  int          stall_n = 0;
  bit          stuck   = 1'b0;
  logic [31:0] id_word = 32'd0;
  logic [31:0] ts_word = EXP_TS;
  int          stall_ctr [2] = '{0, 0};
  logic        acc_p1  = 1'b0;
  logic        acc_p2  = 1'b0;
  logic        addr_p1 = 1'b0;
  logic        addr_p2 = 1'b0;

  always_comb begin
    for (int i = 0; i < 2; i++)
      avm_waitrequest[i] = avm_read[i] && (stuck || (stall_ctr[i] < stall_n));
  end

  always_comb begin
    avm_readdata[0] = (avm_read[0] && !avm_waitrequest[0]) ?
                      (avm_address[0] ? ts_word : id_word) : JUNK;
    avm_readdata[1] = acc_p2 ? (addr_p2 ? ts_word : id_word) : JUNK;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (avm_read[i] && avm_waitrequest[i]) stall_ctr[i] <= stall_ctr[i] + 1;
      else if (!avm_read[i])                 stall_ctr[i] <= 0;
    end
    acc_p1  <= avm_read[1] && !avm_waitrequest[1];
    addr_p1 <= avm_address[1];
    acc_p2  <= acc_p1;
    addr_p2 <= addr_p1;
  end

  // Monitor: records completed sequences and bus-protocol observations
  res_t       obs0 [$];
  res_t       obs1 [$];
  res_t       exp0 [$];
  res_t       exp1 [$];
  int         done_cnt  [2] = '{0, 0};
  int         exp_cnt   [2] = '{0, 0};
  int         cur_run   [2] = '{0, 0};
  int         last_run  [2] = '{0, 0};
  int         addr_viol [2] = '{0, 0};
  int         busy_bad  [2] = '{0, 0};
  logic [1:0] acc_log   [2] = '{2'b00, 2'b00};
  logic       prev_rw   [2] = '{1'b0, 1'b0};
  logic       prev_addr [2] = '{1'b0, 1'b0};
  logic       prev_done [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    res_t r;
    for (int i = 0; i < 2; i++) begin
      if (done[i]) begin
        done_cnt[i] = done_cnt[i] + 1;
        r.id  = id_value[i];
        r.ts  = ts_value[i];
        r.idm = id_match[i];
        r.tsm = ts_match[i];
        r.to  = timeout_err[i];
        if (i == 0) obs0.push_back(r);
        else        obs1.push_back(r);
      end
      if (prev_done[i] && busy[i]) busy_bad[i] = busy_bad[i] + 1;
      if (prev_rw[i] && avm_read[i] && (avm_address[i] != prev_addr[i]))
        addr_viol[i] = addr_viol[i] + 1;
      if (avm_read[i] && !avm_waitrequest[i])
        acc_log[i] = {acc_log[i][0], avm_address[i]};
      if (avm_read[i]) begin
        cur_run[i] = cur_run[i] + 1;
      end else if (cur_run[i] != 0) begin
        last_run[i] = cur_run[i];
        cur_run[i]  = 0;
      end
      prev_done[i] = done[i];
      prev_rw[i]   = avm_read[i] && avm_waitrequest[i];
      prev_addr[i] = avm_address[i];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [71:0] observed, input logic [71:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [1:0] mask, input logic [31:0] id, input logic [31:0] ts,
                          input logic idm, input logic tsm, input logic to);
    res_t r;
    r.id  = id;
    r.ts  = ts;
    r.idm = idm;
    r.tsm = tsm;
    r.to  = to;
    if (mask[0]) begin exp0.push_back(r); exp_cnt[0]++; end
    if (mask[1]) begin exp1.push_back(r); exp_cnt[1]++; end
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s_dut%0d", tag, i),
          {id_value[i], ts_value[i], avm_read[i], avm_address[i], done[i],
           id_match[i], ts_match[i], timeout_err[i], busy[i]}, 72'd1);
  endtask

  // Waits (bounded) for each selected instance to finish a sequence, then scores it
  task automatic check_seq(input logic [1:0] mask, input string tag);
    int   n;
    res_t o;
    res_t e;
    n = 0;
    while (((mask[0] && obs0.size() == 0) || (mask[1] && obs1.size() == 0)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 2; i++) begin
      if (mask[i]) begin
        if (i == 0) begin
          chk($sformatf("%s_done_dut0", tag), 72'(obs0.size() != 0), 72'd1);
          if (obs0.size() != 0) begin
            o = obs0.pop_front();
            e = exp0.pop_front();
            chk($sformatf("%s_result_dut0", tag), 72'(o), 72'(e));
          end
        end else begin
          chk($sformatf("%s_done_dut1", tag), 72'(obs1.size() != 0), 72'd1);
          if (obs1.size() != 0) begin
            o = obs1.pop_front();
            e = exp1.pop_front();
            chk($sformatf("%s_result_dut1", tag), 72'(o), 72'(e));
          end
        end
      end
    end
    cyc(2);
  endtask

  initial begin
    int n;
    int d1;

    // Reset values, then the automatic check after release
    reset_n = 1'b0;
    cyc(3);
    chk_reset("reset");
    push_exp(2'b11, 32'd0, EXP_TS, 1'b1, 1'b1, 1'b0);
    reset_n = 1'b1;
    check_seq(2'b11, "auto");
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("addr_order_dut%0d", i), 72'(acc_log[i]), 72'(2'b01));
      chk($sformatf("done_once_dut%0d", i), 72'(done_cnt[i]), 72'd1);
    end

    // Wrong timestamp from the slave
    ts_word = BAD_TS;
    push_exp(2'b11, 32'd0, BAD_TS, 1'b1, 1'b0, 1'b0);
    pulse_start();
    check_seq(2'b11, "bad_ts");

    // Three waitrequest cycles per read; address must hold while stalled
    ts_word = EXP_TS;
    stall_n = 3;
    push_exp(2'b11, 32'd0, EXP_TS, 1'b1, 1'b1, 1'b0);
    pulse_start();
    check_seq(2'b11, "stall");
    for (int i = 0; i < 2; i++)
      chk($sformatf("stall_run_dut%0d", i), 72'(last_run[i]), 72'd4);

    // Stuck slave: abort after 8 stalled cycles, captured words held
    stuck = 1'b1;
    push_exp(2'b11, 32'd0, EXP_TS, 1'b0, 1'b0, 1'b1);
    pulse_start();
    check_seq(2'b11, "timeout");
    for (int i = 0; i < 2; i++)
      chk($sformatf("timeout_run_dut%0d", i), 72'(last_run[i]), 72'd8);

    // Healthy slave again clears the timeout flag
    stuck   = 1'b0;
    stall_n = 0;
    push_exp(2'b11, 32'd0, EXP_TS, 1'b1, 1'b1, 1'b0);
    pulse_start();
    check_seq(2'b11, "recover");

    // start during WAIT_TS of the latency-2 instance; the other is idle by then
    d1 = done_cnt[1];
    push_exp(2'b11, 32'd0, EXP_TS, 1'b1, 1'b1, 1'b0);
    push_exp(2'b01, 32'd0, EXP_TS, 1'b1, 1'b1, 1'b0);
    pulse_start();
    n = 0;
    while (!(avm_read[1] && avm_address[1] && !avm_waitrequest[1]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ts_reached", 72'(n < 50), 72'd1);
    @(negedge clk);
    pulse_start();
    check_seq(2'b11, "start_in_wait");
    check_seq(2'b01, "restart_dut0");
    chk("single_done_dut1", 72'(done_cnt[1]), 72'(d1 + 1));

    // Reset while the zero-latency instance is stalled reading the timestamp
    stall_n = 3;
    pulse_start();
    n = 0;
    while (!(avm_read[0] && avm_address[0] && avm_waitrequest[0]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rd_ts_stall_reached", 72'(n < 50), 72'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset("mid_reset");
    cyc(2);
    stall_n = 0;
    push_exp(2'b11, 32'd0, EXP_TS, 1'b1, 1'b1, 1'b0);
    reset_n = 1'b1;
    check_seq(2'b11, "post_reset");

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("addr_stable_dut%0d", i), 72'(addr_viol[i]), 72'd0);
      chk($sformatf("busy_after_done_dut%0d", i), 72'(busy_bad[i]), 72'd0);
      chk($sformatf("done_count_dut%0d", i), 72'(done_cnt[i]), 72'(exp_cnt[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysid_check_ctrl.md
Name: sysid_check_ctrl

Overview:
- Avalon-MM master that sequences reads of the system-ID slave: word 0 (ID) at address 0, word 1 (build timestamp) at address 1.
- Compares both words against build-time expected values and publishes match/timeout status to the CPU-side status logic and board LEDs.
- Runs automatically after reset and again on each `start` pulse.
- Sits between the Qsys system-ID slave and the system health/status register block.

Parameters:
- EXPECTED_ID, 0, expected word at address 0.
- EXPECTED_TS, 1490652961, expected word at address 1.
- READ_LATENCY, 0, fixed slave read latency in cycles (legal 0..3); 0 means readdata is valid in the accept cycle.
- TIMEOUT_CYCLES, 255, maximum consecutive waitrequest-high cycles per read before abort (legal 1..65535).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle re-check request.
- avm_address  out  1  slave word address.
- avm_read  out  1  read strobe.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  slave read data.
- id_value  out  32  last captured ID word.
- ts_value  out  32  last captured timestamp word.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- id_match  out  1  id_value == EXPECTED_ID.
- ts_match  out  1  ts_value == EXPECTED_TS.
- timeout_err  out  1  last sequence aborted on timeout.

Behaviour:
- One clock domain. Reset is synchronous, active-low: every register updates only on a rising clock edge with reset_n low.
- Reset values:
  - id_value = ts_value = 0.
  - avm_read = 0, avm_address = 0.
  - done, id_match, ts_match, timeout_err = 0.
  - busy = 1, because the state resets to RD_ID so a check starts automatically on the first cycle after reset release.
- States:
  - IDLE: busy = 0. If start = 1, go to RD_ID.
  - RD_ID: avm_address = 0, avm_read = 1.
    - Accept occurs when avm_waitrequest = 0. On accept, drop avm_read next cycle.
    - READ_LATENCY = 0: capture avm_readdata into id_value in the accept cycle, then go to RD_TS.
    - READ_LATENCY > 0: go to WAIT_ID.
  - WAIT_ID: count READ_LATENCY cycles after accept. Capture avm_readdata on the final count, then go to RD_TS.
  - RD_TS / WAIT_TS: identical to RD_ID / WAIT_ID with avm_address = 1, capturing into ts_value. Exit goes to FINISH.
  - FINISH: for one cycle, pulse done, update id_match/ts_match from the captured words, clear timeout_err, then go to IDLE.
- Timeout:
  - A 16-bit stall counter clears on entry to each RD_* state and increments each cycle avm_read = 1 and avm_waitrequest = 1.
  - When the counter reaches TIMEOUT_CYCLES (with waitrequest still high), deassert avm_read next cycle and go to ABORT.
- ABORT: for one cycle, pulse done, set timeout_err = 1, force id_match = ts_match = 0, leave id_value/ts_value holding the last captured values, then go to IDLE.
- Avalon rules:
  - avm_address and avm_read are registered.
  - avm_address stays stable while avm_read = 1 and waitrequest = 1.
  - At most one read is outstanding; no new read is issued until the previous data is captured.
- start while busy is ignored; no queuing.
- start in the FINISH or ABORT cycle is also ignored. IDLE samples start on the following cycle.
- Status outputs (id_match, ts_match, timeout_err) hold between sequences. They change only in the FINISH or ABORT cycle.
- Reset asserted mid-sequence: the outstanding read is abandoned, all outputs return to reset values, and the auto-check restarts after reset release. Data returned late from an abandoned read is ignored.
- Comparisons are full 32-bit equality with no masking.

Test Plan:
- Slave stub returns 0 at address 0 and 1490652961 at address 1, waitrequest tied 0, READ_LATENCY = 0. Release reset -> avm_read asserted at address 0 then address 1; done pulses exactly once; id_match = 1, ts_match = 1, timeout_err = 0; busy falls the cycle after done.
- Stub returns 0x5AD9_6E22 at address 1, then pulse start -> ts_value = 0x5AD96E22, ts_match = 0, id_match = 1.
- READ_LATENCY = 2, waitrequest high for 3 cycles per read -> address held stable during the stall; data captured exactly 2 cycles after accept; both matches = 1.
- waitrequest stuck at 1, TIMEOUT_CYCLES = 8 -> avm_read drops after 8 stalled cycles; done pulses; timeout_err = 1, id_match = ts_match = 0; a later start with a healthy slave clears timeout_err.
- Pulse start while in WAIT_TS -> ignored; exactly one done pulse.
- Assert reset_n low during RD_TS stall -> outputs return to reset values next edge; after release a full auto-check completes normally.
